posit_encoder: RTL and testbench

//  Final stage of the posit datapath, directly downstream of the posit decoder and arithmetic core.

---
 rtl/posit_pkg.sv | 31 +++
 rtl/posit_round_rne.sv | 38 +++
 rtl/posit_encoder.sv | 177 +++++++++++++++++
 tb/tb_posit_encoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// posit_pkg -- shared constants for the 32-bit, es=3 posit datapath.
//   Posit geometry (N, ES), special encodings, encoder frame/magnitude
//   widths, encoder state encodings, regime clamp limits and a helper
//   that derives the regime run length from k.
package posit_pkg;

  localparam int unsigned N       = 32;
  localparam int unsigned ES      = 3;
  localparam int unsigned MAG_W   = N - 1;              // magnitude bits below the sign
  localparam int unsigned FRAME_W = ES + MAG_W + MAG_W; // exp + fraction + room for regime

  localparam logic [N-1:0] POSIT_MAXPOS = 32'h7FFF_FFFF;
  localparam logic [N-1:0] POSIT_MINPOS = 32'h0000_0001;
  localparam logic [N-1:0] POSIT_NAR    = 32'h8000_0000;
  localparam logic [N-1:0] POSIT_ZERO   = 32'h0000_0000;

  localparam logic signed [5:0] K_MAX = 6'sd30;
  localparam logic signed [5:0] K_MIN = -6'sd31;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REGIME   = 2'd1;
  localparam logic [1:0] ST_ROUND    = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  // Regime run length: k+2 for k>=0, 1-k for k<0 (6-bit wraparound is exact here).
  function automatic logic [5:0] regime_len(input logic [5:0] k);
    if (!k[5]) return k + 6'd2;
    else       return 6'd1 - k;
  endfunction

endpackage

// File: rtl/posit_round_rne.sv
// posit_round_rne -- combinational round-to-nearest-even of a 31-bit posit
// magnitude, saturating to maxpos and never returning zero.
//   mag         in  31  truncated magnitude
//   guard       in  1   first discarded bit
//   sticky      in  1   OR of all further discarded bits
//   mag_rounded out 31  rounded magnitude
//   inexact     out 1   any discarded bit was set
//   overflow    out 1   rounding carried out of, or up onto, maxpos
module posit_round_rne
  import posit_pkg::*;
(
  input  logic [MAG_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  output logic [MAG_W-1:0] mag_rounded,
  output logic             inexact,
  output logic             overflow
);

  logic           inc;
  logic [MAG_W:0] sum;

  always_comb begin
    inc = guard & (sticky | mag[0]);
    sum = {1'b0, mag} + {{MAG_W{1'b0}}, inc};
    if (sum[MAG_W])
      mag_rounded = POSIT_MAXPOS[MAG_W-1:0];
    else if (sum[MAG_W-1:0] == '0)
      mag_rounded = POSIT_MINPOS[MAG_W-1:0];
    else
      mag_rounded = sum[MAG_W-1:0];
    inexact = guard | sticky;
    // Rounding up onto the all-ones magnitude means the value has been pushed
    // into maxpos, so it is reported the same way as a carry-out clamp.
    overflow = inc & (&mag[MAG_W-1:1]);
  end

endmodule

// File: rtl/posit_encoder.sv
// posit_encoder -- packs decoded {sign, k, exp, mantissa} into a 32-bit posit
// (es=3). The regime is inserted serially one bit per cycle, then the
// magnitude is rounded (RNE) and two's-complemented for negative results.
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-low reset
//   start      in   1   request, sampled only when idle
//   sign       in   1   result sign
//   k          in   6   signed regime value
//   exp_value  in   3   exponent field
//   mantissa   in   32  bit31 hidden 1, fraction in [30:0]
//   zero_in    in   1   force 0x00000000
//   nar_in     in   1   force 0x80000000 (wins over zero_in)
//   posit_num  out  32  encoded posit, held until the next result
//   done       out  1   one-cycle pulse when posit_num is updated
//   busy       out  1   high whenever not idle
// Optional (POSIT_ENC_FLAGS_EN defined):
//   inexact    out  1   discarded bits were non-zero
//   saturated  out  1   k clamp or rounding clamp to maxpos
module posit_encoder
  import posit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sign,
  input  logic [5:0]    k,
  input  logic [2:0]    exp_value,
  input  logic [31:0]   mantissa,
  input  logic          zero_in,
  input  logic          nar_in,
  output logic [N-1:0]  posit_num,
  output logic          done,
  output logic          busy
`ifdef POSIT_ENC_FLAGS_EN
  ,
  output logic          inexact,
  output logic          saturated
`endif
);

  logic [1:0]         state;
  logic [FRAME_W-1:0] frame;
  logic [5:0]         cnt;
  logic [5:0]         r_len;
  logic               k_neg;
  logic               sign_q;
  logic               special_q;
  logic [N-1:0]       special_val;
  logic [MAG_W-1:0]   mag_q;
  logic               regime_bit;

  logic signed [5:0]  k_s;
  logic [MAG_W-1:0]   rnd_mag;
  logic               rnd_inexact;
  logic               rnd_overflow;
  logic               unused_hidden;

  assign k_s           = k;
  assign unused_hidden = mantissa[31];
  assign busy          = (state != ST_IDLE);

  // Bits are pushed in at the MSB, so the terminating bit goes first and the
  // run of repeated bits follows, leaving the regime MSB-first after r shifts.
  assign regime_bit = (cnt == 6'd0) ? k_neg : ~k_neg;

  posit_round_rne u_round (
    .mag         (frame[FRAME_W-1 -: MAG_W]),
    .guard       (frame[FRAME_W-1-MAG_W]),
    .sticky      (|frame[FRAME_W-2-MAG_W:0]),
    .mag_rounded (rnd_mag),
    .inexact     (rnd_inexact),
    .overflow    (rnd_overflow)
  );

`ifdef POSIT_ENC_FLAGS_EN
  logic inexact_p;
  logic saturated_p;
`endif

  // Special operands also pass through ROUND (without rounding) so every
  // result leaves from the same ROUND -> COMPLETE tail.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      frame       <= '0;
      cnt         <= '0;
      r_len       <= '0;
      k_neg       <= 1'b0;
      sign_q      <= 1'b0;
      special_q   <= 1'b0;
      special_val <= '0;
      mag_q       <= '0;
      posit_num   <= '0;
      done        <= 1'b0;
`ifdef POSIT_ENC_FLAGS_EN
      inexact_p   <= 1'b0;
      saturated_p <= 1'b0;
      inexact     <= 1'b0;
      saturated   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sign_q    <= sign;
            k_neg     <= k[5];
            special_q <= 1'b1;
`ifdef POSIT_ENC_FLAGS_EN
            inexact_p   <= 1'b0;
            saturated_p <= 1'b0;
`endif
            if (nar_in) begin
              special_val <= POSIT_NAR;
              state       <= ST_ROUND;
            end else if (zero_in) begin
              special_val <= POSIT_ZERO;
              state       <= ST_ROUND;
            end else if (k_s >= K_MAX) begin
              special_val <= sign ? (POSIT_ZERO - POSIT_MAXPOS) : POSIT_MAXPOS;
              state       <= ST_ROUND;
`ifdef POSIT_ENC_FLAGS_EN
              saturated_p <= 1'b1;
`endif
            end else if (k_s <= K_MIN) begin
              special_val <= sign ? (POSIT_ZERO - POSIT_MINPOS) : POSIT_MINPOS;
              state       <= ST_ROUND;
`ifdef POSIT_ENC_FLAGS_EN
              saturated_p <= 1'b1;
`endif
            end else begin
              special_q <= 1'b0;
              frame     <= {exp_value, mantissa[30:0], {MAG_W{1'b0}}};
              r_len     <= regime_len(k);
              cnt       <= '0;
              state     <= ST_REGIME;
            end
          end
        end
        ST_REGIME: begin
          frame <= {regime_bit, frame[FRAME_W-1:1]};
          cnt   <= cnt + 6'd1;
          if (cnt == r_len - 6'd1)
            state <= ST_ROUND;
        end
        ST_ROUND: begin
          if (!special_q) begin
            mag_q <= rnd_mag;
`ifdef POSIT_ENC_FLAGS_EN
            inexact_p   <= rnd_inexact;
            saturated_p <= rnd_overflow;
`endif
          end
          state <= ST_COMPLETE;
        end
        default: begin
          if (special_q)
            posit_num <= special_val;
          else
            posit_num <= sign_q ? (POSIT_ZERO - {1'b0, mag_q}) : {1'b0, mag_q};
          done  <= 1'b1;
          state <= ST_IDLE;
`ifdef POSIT_ENC_FLAGS_EN
          inexact   <= inexact_p;
          saturated <= saturated_p;
`endif
        end
      endcase
    end
  end

`ifndef POSIT_ENC_FLAGS_EN
  logic unused_flags;
  assign unused_flags = rnd_inexact | rnd_overflow;
`endif

endmodule

// File: tb/tb_posit_encoder.sv
// tb_posit_encoder -- directed-vector bench for posit_encoder.
//   Drives hand-computed operands, checks result value, done latency,
//   pulse width, hold behaviour, busy-ignore and mid-operation reset.
//   Flag outputs are checked when POSIT_ENC_FLAGS_EN is defined.
module tb_posit_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [5:0]  k = '0;
  logic [2:0]  exp_value = '0;
  logic [31:0] mantissa = '0;
  logic        zero_in = 1'b0;
  logic        nar_in = 1'b0;
  logic [31:0] posit_num;
  logic        done;
  logic        busy;
`ifdef POSIT_ENC_FLAGS_EN
  logic        inexact;
  logic        saturated;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  posit_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign      (sign),
    .k         (k),
    .exp_value (exp_value),
    .mantissa  (mantissa),
    .zero_in   (zero_in),
    .nar_in    (nar_in),
    .posit_num (posit_num),
    .done      (done),
    .busy      (busy)
`ifdef POSIT_ENC_FLAGS_EN
    ,
    .inexact   (inexact),
    .saturated (saturated)
`endif
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issues one request and waits (bounded) for done; lat = edges after the
  // start-sampling edge, 0 if done never came.
  task automatic run_op(input logic sg, input logic [5:0] kk, input logic [2:0] ex,
                        input logic [31:0] mt, input logic z, input logic nr,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    sign = sg; k = kk; exp_value = ex; mantissa = mt; zero_in = z; nar_in = nr;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    res = posit_num;
  endtask

  typedef struct {
    string       name;
    logic        sg;
    logic [5:0]  kk;
    logic [2:0]  ex;
    logic [31:0] mt;
    logic        z;
    logic        nr;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] res;
  int          lat;
  int          n_done;

  initial begin
    // k values: 6'h3F=-1, 6'h3D=-3, 6'h22=-30, 6'h21=-31
    vecs.push_back('{"k0_pos",      1'b0, 6'd0,  3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h4000_0000, 4});
    vecs.push_back('{"k0_neg",      1'b1, 6'd0,  3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'hC000_0000, 4});
    vecs.push_back('{"km1",         1'b0, 6'h3F, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h2000_0000, 4});
    vecs.push_back('{"tie_even",    1'b0, 6'd0,  3'd0, 32'h8000_0010, 1'b0, 1'b0, 32'h4000_0000, 4});
    vecs.push_back('{"tie_odd",     1'b0, 6'd0,  3'd0, 32'h8000_0030, 1'b0, 1'b0, 32'h4000_0002, 4});
    vecs.push_back('{"k2_e5",       1'b0, 6'd2,  3'd5, 32'hC000_0000, 1'b0, 1'b0, 32'h7580_0000, 6});
    vecs.push_back('{"k2_e5_neg",   1'b1, 6'd2,  3'd5, 32'hC000_0000, 1'b0, 1'b0, 32'h8A80_0000, 6});
    vecs.push_back('{"km3_e2",      1'b0, 6'h3D, 3'd2, 32'hA000_0000, 1'b0, 1'b0, 32'h0A40_0000, 6});
    vecs.push_back('{"km30_min",    1'b0, 6'h22, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0001, 33});
    vecs.push_back('{"k30_sat",     1'b0, 6'd30, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 2});
    vecs.push_back('{"km31_sat_neg",1'b1, 6'h21, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 32'hFFFF_FFFF, 2});
    vecs.push_back('{"k29_e7_rnd",  1'b0, 6'd29, 3'd7, 32'h8000_0000, 1'b0, 1'b0, 32'h7FFF_FFFF, 33});
    vecs.push_back('{"nar",         1'b1, 6'd3,  3'd1, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 2});
    vecs.push_back('{"zero",        1'b1, 6'd3,  3'd1, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 2});
    vecs.push_back('{"nar_over_zero",1'b0,6'd0,  3'd0, 32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000, 2});

    // reset state
    #1;
    check("rst_posit", posit_num, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].sg, vecs[i].kk, vecs[i].ex, vecs[i].mt, vecs[i].z, vecs[i].nr, res, lat);
      check({vecs[i].name, "_val"}, res, vecs[i].exp_res);
      check({vecs[i].name, "_lat"}, lat, vecs[i].exp_lat);
`ifdef POSIT_ENC_FLAGS_EN
      if (vecs[i].name == "k29_e7_rnd") begin
        check("k29_e7_saturated", {31'b0, saturated}, 32'h1);
        check("k29_e7_inexact", {31'b0, inexact}, 32'h1);
      end
      if (vecs[i].name == "k0_pos")
        check("k0_flags", {30'b0, saturated, inexact}, 32'h0);
      if (vecs[i].name == "k30_sat")
        check("k30_saturated", {31'b0, saturated}, 32'h1);
`endif
    end

    // done is a single-cycle pulse and the result is held afterwards
    run_op(1'b0, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, res, lat);
    @(posedge clk); #1;
    check("done_pulse_width", {31'b0, done}, 32'h0);
    repeat (3) @(posedge clk);
    #1 check("posit_hold", posit_num, 32'h4000_0000);

    // second start while busy must be ignored
    @(negedge clk);
    sign = 1'b0; k = 6'd0; exp_value = 3'd0; mantissa = 32'h8000_0000;
    zero_in = 1'b0; nar_in = 1'b0; start = 1'b1;
    @(negedge clk);
    check("busy_after_start", {31'b0, busy}, 32'h1);
    k = 6'h3F; start = 1'b1;
    @(negedge clk) start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        res = posit_num;
      end
    end
    check("busy_ignore_count", n_done, 1);
    check("busy_ignore_val", res, 32'h4000_0000);

    // reset in the middle of REGIME (k=5 -> 7 regime cycles)
    @(negedge clk);
    k = 6'd5; start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_posit", posit_num, 32'h0);
    check("midrst_done", {31'b0, done}, 32'h0);
    check("midrst_busy", {31'b0, busy}, 32'h0);
    @(negedge clk) rst = 1'b1;
    run_op(1'b0, 6'd0, 3'd0, 32'h8000_0000, 1'b0, 1'b0, res, lat);
    check("after_rst_val", res, 32'h4000_0000);
    check("after_rst_lat", lat, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
